// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle core control path: FSM states, opcodes and the
// select/operation codes consumed by ALU_Ctrl and the datapath muxes.
package mc_pkg;

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StHalt   = 3'd7
   } state_e;

   localparam logic [6:0] OpcR   = 7'b0110011;
   localparam logic [6:0] OpcI   = 7'b0010011;
   localparam logic [6:0] OpcLw  = 7'b0000011;
   localparam logic [6:0] OpcSw  = 7'b0100011;
   localparam logic [6:0] OpcBr  = 7'b1100011;
   localparam logic [6:0] OpcJal = 7'b1101111;

   typedef enum logic [1:0] {
      AluOpAdd   = 2'b00,
      AluOpSub   = 2'b01,
      AluOpRType = 2'b10,
      AluOpIType = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      PcSrcPlus4  = 2'd0,
      PcSrcTarget = 2'd1,
      PcSrcHold   = 2'd2
   } pc_src_e;

   typedef enum logic [1:0] {
      WbSelAlu = 2'd0,
      WbSelMem = 2'd1,
      WbSelPc4 = 2'd2
   } wb_sel_e;

   typedef enum logic {
      AluSrcARs = 1'b0,
      AluSrcAPc = 1'b1
   } alu_src_a_e;

   typedef enum logic [1:0] {
      AluSrcBRt   = 2'd0,
      AluSrcBImm  = 2'd1,
      AluSrcBFour = 2'd2
   } alu_src_b_e;

   typedef enum logic [2:0] {
      ClsR,
      ClsI,
      ClsLw,
      ClsSw,
      ClsBr,
      ClsJal
   } instr_cls_e;

   typedef struct packed {
      logic       valid;
      instr_cls_e cls;
   } dec_t;

   function automatic dec_t decode_opcode(input logic [6:0] opcode);
      dec_t d;
      d.valid = 1'b1;
      d.cls   = ClsR;
      case (opcode)
         OpcR:    d.cls = ClsR;
         OpcI:    d.cls = ClsI;
         OpcLw:   d.cls = ClsLw;
         OpcSw:   d.cls = ClsSw;
         OpcBr:   d.cls = ClsBr;
         OpcJal:  d.cls = ClsJal;
         default: d.valid = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port handshake between the control FSM and memory.
interface multicycle_ctrl_if;

   logic mem_req;
   logic mem_we;
   logic mem_sel;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output mem_sel,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_sel,
      output mem_ready
   );

endinterface

// File: rtl/multicycle_ctrl_timeout_cnt.sv
// Memory wait counter: counts consecutive stalled request cycles and flags the cycle in
// which the Timeout-th stall completes.
module mc_timeout_cnt #(
   parameter int unsigned Timeout = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic wait_i,
   output logic expired_o
);

   localparam int unsigned CntW = $clog2(Timeout);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign expired_o = wait_i && (cnt_q == CntW'(Timeout - 1));

   // Any cycle without a pending stall (ready, idle, halted) restarts the count.
   always_comb begin
      cnt_d = '0;
      if (wait_i && !expired_o) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I-subset core (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Define PERF_CNT_EN to add the cycle_cnt_o / retire_cnt_o performance counters.
module multicycle_ctrl
   import mc_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
`ifdef PERF_CNT_EN
   ,
   parameter int unsigned CNT_W   = 32
`endif
) (
   input  logic                clk_i,
   input  logic                rst_i,
   multicycle_ctrl_if.master   mem,
   input  logic [6:0]          opcode_i,
   input  logic [2:0]          funct3_i,
   input  logic                zero_i,
   output logic                ir_we_o,
   output logic                pc_we_o,
   output logic [1:0]          pc_src_o,
   output logic                reg_we_o,
   output logic [1:0]          wb_sel_o,
   output logic                alu_src_a_o,
   output logic [1:0]          alu_src_b_o,
   output logic [1:0]          alu_op_o,
   output logic [2:0]          state_o,
`ifdef PERF_CNT_EN
   output logic [CNT_W-1:0]    cycle_cnt_o,
   output logic [CNT_W-1:0]    retire_cnt_o,
`endif
   output logic                err_o
);

   state_e     state_q, state_d;
   instr_cls_e cls_q, cls_d;
   logic       br_ne_q, br_ne_d;
   logic       err_q, err_d;
   dec_t       dec;
   logic       tmo_expired;

   logic       mem_req, mem_we, mem_sel;
   logic       ir_we, pc_we, reg_we;
   pc_src_e    pc_src;
   wb_sel_e    wb_sel;
   alu_src_a_e alu_src_a;
   alu_src_b_e alu_src_b;
   alu_op_e    alu_op;
   logic       taken;

   assign dec   = decode_opcode(opcode_i);
   assign taken = zero_i ^ br_ne_q;

   mc_timeout_cnt #(
      .Timeout (TIMEOUT)
   ) u_timeout_cnt (
      .clk_i     (clk_i),
      .rst_ni    (rst_i),
      .wait_i    (mem_req && !mem.mem_ready),
      .expired_o (tmo_expired)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= StFetch;
         cls_q   <= ClsR;
         br_ne_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         br_ne_q <= br_ne_d;
         err_q   <= err_d;
      end
   end

   // Instruction class and branch sense are captured once in DECODE so later IR
   // changes cannot redirect the sequence.
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      br_ne_d = br_ne_q;
      err_d   = err_q;
      unique case (state_q)
         StFetch: begin
            if (mem.mem_ready) begin
               state_d = StDecode;
            end else if (tmo_expired) begin
               state_d = StHalt;
            end
         end
         StDecode: begin
            if (dec.valid) begin
               cls_d   = dec.cls;
               br_ne_d = funct3_i[0];
               state_d = StExec;
            end else begin
               state_d = StHalt;
            end
         end
         StExec: begin
            unique case (cls_q)
               ClsR, ClsI:   state_d = StWb;
               ClsLw, ClsSw: state_d = StMem;
               default:      state_d = StFetch;
            endcase
         end
         StMem: begin
            if (mem.mem_ready) begin
               state_d = (cls_q == ClsSw) ? StFetch : StWb;
            end else if (tmo_expired) begin
               state_d = StHalt;
            end
         end
         StWb:    state_d = StFetch;
         StHalt:  state_d = StHalt;
         default: state_d = StHalt;
      endcase
      if (state_d == StHalt) begin
         err_d = 1'b1;
      end
   end

   // Outputs are forced idle while reset is asserted so a request dies with rst_i,
   // not at the next clock edge.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_sel   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = PcSrcPlus4;
      reg_we    = 1'b0;
      wb_sel    = WbSelAlu;
      alu_src_a = AluSrcARs;
      alu_src_b = AluSrcBRt;
      alu_op    = AluOpAdd;
      if (rst_i) begin
         unique case (state_q)
            StFetch: begin
               mem_req = 1'b1;
               if (mem.mem_ready) begin
                  ir_we = 1'b1;
                  pc_we = 1'b1;
               end
            end
            StExec: begin
               unique case (cls_q)
                  ClsR: alu_op = AluOpRType;
                  ClsI: begin
                     alu_src_b = AluSrcBImm;
                     alu_op    = AluOpIType;
                  end
                  ClsLw, ClsSw: alu_src_b = AluSrcBImm;
                  ClsBr: begin
                     alu_op = AluOpSub;
                     if (taken) begin
                        pc_we  = 1'b1;
                        pc_src = PcSrcTarget;
                     end
                  end
                  ClsJal: begin
                     reg_we = 1'b1;
                     wb_sel = WbSelPc4;
                     pc_we  = 1'b1;
                     pc_src = PcSrcTarget;
                  end
                  default: ;
               endcase
            end
            StMem: begin
               mem_req   = 1'b1;
               mem_sel   = 1'b1;
               mem_we    = (cls_q == ClsSw);
               alu_src_b = AluSrcBImm;
            end
            StWb: begin
               reg_we = 1'b1;
               // R/I results come straight off the ALU, so keep its operands steady.
               unique case (cls_q)
                  ClsLw: wb_sel = WbSelMem;
                  ClsR:  alu_op = AluOpRType;
                  ClsI: begin
                     alu_src_b = AluSrcBImm;
                     alu_op    = AluOpIType;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign mem.mem_req  = mem_req;
   assign mem.mem_we   = mem_we;
   assign mem.mem_sel  = mem_sel;
   assign ir_we_o      = ir_we;
   assign pc_we_o      = pc_we;
   assign pc_src_o     = pc_src;
   assign reg_we_o     = reg_we;
   assign wb_sel_o     = wb_sel;
   assign alu_src_a_o  = alu_src_a;
   assign alu_src_b_o  = alu_src_b;
   assign alu_op_o     = alu_op;
   assign state_o      = state_q;
   assign err_o        = err_q;

`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
   logic             retire;

   assign retire = (state_q inside {StExec, StMem, StWb}) && (state_d == StFetch);

   always_comb begin
      cycle_cnt_d  = cycle_cnt_q;
      retire_cnt_d = retire_cnt_q;
      if (state_q != StHalt) begin
         cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      end
      if (retire) begin
         retire_cnt_d = retire_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cycle_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         cycle_cnt_q  <= cycle_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign cycle_cnt_o  = cycle_cnt_q;
   assign retire_cnt_o = retire_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: inputs change on the falling edge, outputs are
// checked 1 ns later, state advances on the rising edge.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_i;
   logic [6:0] opcode_i;
   logic [2:0] funct3_i;
   logic       zero_i;
   logic       ir_we_o, pc_we_o, reg_we_o, alu_src_a_o, err_o;
   logic [1:0] pc_src_o, wb_sel_o, alu_src_b_o, alu_op_o;
   logic [2:0] state_o;
`ifdef PERF_CNT_EN
   logic [31:0] cycle_cnt_o, retire_cnt_o;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(
      .TIMEOUT (16)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .mem          (bus.master),
      .opcode_i     (opcode_i),
      .funct3_i     (funct3_i),
      .zero_i       (zero_i),
      .ir_we_o      (ir_we_o),
      .pc_we_o      (pc_we_o),
      .pc_src_o     (pc_src_o),
      .reg_we_o     (reg_we_o),
      .wb_sel_o     (wb_sel_o),
      .alu_src_a_o  (alu_src_a_o),
      .alu_src_b_o  (alu_src_b_o),
      .alu_op_o     (alu_op_o),
      .state_o      (state_o),
`ifdef PERF_CNT_EN
      .cycle_cnt_o  (cycle_cnt_o),
      .retire_cnt_o (retire_cnt_o),
`endif
      .err_o        (err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_i         = 1'b0;
      opcode_i      = 7'b0110011;
      funct3_i      = 3'b000;
      zero_i        = 1'b0;
      bus.mem_ready = 1'b0;

      // Reset state
      #1;
      chk("rst_state", state_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_ir_we", ir_we_o, 0);
      chk("rst_pc_we", pc_we_o, 0);
      chk("rst_reg_we", reg_we_o, 0);
      chk("rst_alu_op", alu_op_o, 0);
      chk("rst_pc_src", pc_src_o, 0);

      // R-type add, zero-wait memory: 0,1,2,4,0
      @(negedge clk); rst_i = 1'b1; bus.mem_ready = 1'b1; #1;
      chk("r_c1_state", state_o, 0);
      chk("r_c1_mem_req", bus.mem_req, 1);
      chk("r_c1_mem_sel", bus.mem_sel, 0);
      chk("r_c1_ir_we", ir_we_o, 1);
      chk("r_c1_pc_we", pc_we_o, 1);
      chk("r_c1_pc_src", pc_src_o, 0);
      chk("r_c1_reg_we", reg_we_o, 0);
      @(negedge clk); #1;
      chk("r_c2_state", state_o, 1);
      chk("r_c2_pc_we", pc_we_o, 0);
      chk("r_c2_reg_we", reg_we_o, 0);
      chk("r_c2_mem_req", bus.mem_req, 0);
      @(negedge clk); #1;
      chk("r_c3_state", state_o, 2);
      chk("r_c3_alu_op", alu_op_o, 2);
      chk("r_c3_alu_src_b", alu_src_b_o, 0);
      chk("r_c3_reg_we", reg_we_o, 0);
      chk("r_c3_pc_we", pc_we_o, 0);
      @(negedge clk); #1;
      chk("r_c4_state", state_o, 4);
      chk("r_c4_reg_we", reg_we_o, 1);
      chk("r_c4_wb_sel", wb_sel_o, 0);
      chk("r_c4_pc_we", pc_we_o, 0);

      // LW with 3 wait cycles; opcode changes after DECODE must not matter
      @(negedge clk); opcode_i = 7'b0000011; #1;
      chk("lw_fetch_state", state_o, 0);
      chk("lw_fetch_ir_we", ir_we_o, 1);
      @(negedge clk); #1;
      chk("lw_dec_state", state_o, 1);
      @(negedge clk); opcode_i = 7'b0100011; bus.mem_ready = 1'b0; #1;
      chk("lw_exec_state", state_o, 2);
      chk("lw_exec_alu_src_b", alu_src_b_o, 1);
      chk("lw_exec_alu_op", alu_op_o, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("lw_wait_state", state_o, 3);
         chk("lw_wait_mem_req", bus.mem_req, 1);
         chk("lw_wait_mem_sel", bus.mem_sel, 1);
         chk("lw_wait_mem_we", bus.mem_we, 0);
      end
      @(negedge clk); bus.mem_ready = 1'b1; #1;
      chk("lw_mem_state", state_o, 3);
      chk("lw_mem_we", bus.mem_we, 0);
      @(negedge clk); #1;
      chk("lw_wb_state", state_o, 4);
      chk("lw_wb_reg_we", reg_we_o, 1);
      chk("lw_wb_wb_sel", wb_sel_o, 1);
      chk("lw_wb_mem_we", bus.mem_we, 0);

      // BEQ taken on zero
      @(negedge clk); opcode_i = 7'b1100011; funct3_i = 3'b000; #1;
      chk("lw_done_state", state_o, 0);
      @(negedge clk); #1;
      chk("beq_dec_state", state_o, 1);
      @(negedge clk); zero_i = 1'b1; #1;
      chk("beq_exec_state", state_o, 2);
      chk("beq_exec_alu_op", alu_op_o, 1);
      chk("beq_exec_pc_we", pc_we_o, 1);
      chk("beq_exec_pc_src", pc_src_o, 1);
      chk("beq_exec_reg_we", reg_we_o, 0);

      // BNE with zero=1 is not taken; zero=0 is
      @(negedge clk); funct3_i = 3'b001; #1;
      chk("bne_fetch_state", state_o, 0);
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("bne_exec_state", state_o, 2);
      chk("bne_z1_pc_we", pc_we_o, 0);
      zero_i = 1'b0; #1;
      chk("bne_z0_pc_we", pc_we_o, 1);
      chk("bne_z0_pc_src", pc_src_o, 1);

      // JAL
      @(negedge clk); opcode_i = 7'b1101111; #1;
      chk("jal_fetch_state", state_o, 0);
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("jal_exec_state", state_o, 2);
      chk("jal_exec_reg_we", reg_we_o, 1);
      chk("jal_exec_wb_sel", wb_sel_o, 2);
      chk("jal_exec_pc_we", pc_we_o, 1);
      chk("jal_exec_pc_src", pc_src_o, 1);

      // SW, reset asserted mid-MEM
      @(negedge clk); opcode_i = 7'b0100011; #1;
      chk("sw_fetch_state", state_o, 0);
      @(negedge clk); #1;
      @(negedge clk); bus.mem_ready = 1'b0; #1;
      chk("sw_exec_state", state_o, 2);
      chk("sw_exec_alu_src_b", alu_src_b_o, 1);
      @(negedge clk); #1;
      chk("sw_mem_state", state_o, 3);
      chk("sw_mem_req", bus.mem_req, 1);
      chk("sw_mem_we", bus.mem_we, 1);
      chk("sw_mem_sel", bus.mem_sel, 1);
      #2; rst_i = 1'b0; #1;
      chk("sw_rst_mem_req", bus.mem_req, 0);
      chk("sw_rst_mem_we", bus.mem_we, 0);
      chk("sw_rst_state", state_o, 0);

      // Release into FETCH, then hold mem_ready low until timeout
      @(negedge clk); rst_i = 1'b1; #1;
      chk("rel_state", state_o, 0);
      chk("rel_mem_req", bus.mem_req, 1);
      chk("rel_mem_sel", bus.mem_sel, 0);
      chk("rel_mem_we", bus.mem_we, 0);
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk); #1;
         chk("tmo_wait_state", state_o, 0);
         chk("tmo_wait_err", err_o, 0);
         chk("tmo_wait_mem_req", bus.mem_req, 1);
      end
      @(negedge clk); #1;
      chk("tmo_state", state_o, 7);
      chk("tmo_err", err_o, 1);
      chk("tmo_mem_req", bus.mem_req, 0);

      // Illegal opcode halts after DECODE; err stays set
      @(negedge clk); rst_i = 1'b0; #1;
      chk("ill_rst_err", err_o, 0);
      @(negedge clk); rst_i = 1'b1; opcode_i = 7'b1111111; bus.mem_ready = 1'b1; #1;
      chk("ill_fetch_state", state_o, 0);
      @(negedge clk); #1;
      chk("ill_dec_state", state_o, 1);
      chk("ill_dec_err", err_o, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); bus.mem_ready = i[0]; #1;
         chk("ill_halt_state", state_o, 7);
         chk("ill_halt_err", err_o, 1);
         chk("ill_halt_mem_req", bus.mem_req, 0);
         chk("ill_halt_ir_we", ir_we_o, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
